load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_access_check.sv | 63 ++++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 codes, slice width-mode codes and FSM states.
package lsu_pkg;

  localparam int unsigned MEM_AW = 11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WMODE_WORD = 2'b00;
  localparam logic [1:0] WMODE_HALF = 2'b01;
  localparam logic [1:0] WMODE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_access_check.sv
// Combinational request decode: legality, range, width/sign codes and slice offset.
// Build option: MISALIGN_TRAP_EN makes misaligned halfword/word accesses fault.
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SLICE_BYTES = 2048
) (
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  output logic              fault_o,
  output logic [1:0]        width_mode_o,
  output logic              signed_mode_o,
  output logic [MEM_AW-1:0] offset_o
);

  logic [31:0] off;
  logic        legal_f3;
  logic        in_range;
  logic        misaligned;

  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
  assign off      = addr_i - BASE_ADDR;
  assign in_range = (off < SLICE_BYTES);
  assign offset_o = off[MEM_AW-1:0];

  always_comb begin
    legal_f3      = 1'b1;
    width_mode_o  = WMODE_WORD;
    signed_mode_o = 1'b0;
    case (funct3_i)
      F3_B: begin
        width_mode_o  = WMODE_BYTE;
        signed_mode_o = 1'b1;
      end
      F3_H: begin
        width_mode_o  = WMODE_HALF;
        signed_mode_o = 1'b1;
      end
      F3_W: width_mode_o = WMODE_WORD;
      F3_BU: begin
        width_mode_o = WMODE_BYTE;
        legal_f3     = !we_i;
      end
      F3_HU: begin
        width_mode_o = WMODE_HALF;
        legal_f3     = !we_i;
      end
      default: legal_f3 = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((width_mode_o == WMODE_HALF) && addr_i[0]) ||
                      ((width_mode_o == WMODE_WORD) && (addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign fault_o = !legal_f3 || !in_range || misaligned;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a core request/response port to a 2K memory slice.
// Build option: define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SLICE_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [1:0]        mem_width_mode,
  output logic              mem_signed_mode,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [1:0]        wmode_q;
  logic              smode_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic              chk_fault;
  logic [1:0]        chk_wmode;
  logic              chk_smode;
  logic [MEM_AW-1:0] chk_off;
  logic              accept;

  lsu_access_check #(
    .BASE_ADDR  (BASE_ADDR),
    .SLICE_BYTES(SLICE_BYTES)
  ) u_check (
    .we_i         (req_we),
    .funct3_i     (req_funct3),
    .addr_i       (req_addr),
    .fault_o      (chk_fault),
    .width_mode_o (chk_wmode),
    .signed_mode_o(chk_smode),
    .offset_o     (chk_off)
  );

  assign accept = (state_q == ST_IDLE) && req_valid && !rst;

  always_comb begin
    state_d         = state_q;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_err        = 1'b0;
    mem_ren         = 1'b0;
    mem_wen         = 1'b0;
    mem_width_mode  = '0;
    mem_signed_mode = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = !rst;
        if (accept) state_d = chk_fault ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE, ST_CAPTURE: begin
        mem_ren         = !we_q;
        mem_wen         = we_q && (state_q == ST_ISSUE);
        mem_width_mode  = wmode_q;
        mem_signed_mode = smode_q;
        mem_addr        = addr_q;
        mem_wdata       = wdata_q;
        if (state_q == ST_ISSUE) state_d = we_q ? ST_RESP : ST_CAPTURE;
        else                     state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // funct3 is latched in decoded form (width/sign codes); nothing downstream needs the raw field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      wmode_q <= '0;
      smode_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        wmode_q <= chk_wmode;
        smode_q <= chk_smode;
        addr_q  <= chk_off;
        wdata_q <= req_wdata;
        err_q   <= chk_fault;
        rdata_q <= '0;
      end else if (state_q == ST_CAPTURE) begin
        rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a request-level byte-array model.
module tb_load_store_unit;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned SLICE = 2048;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_ren, mem_wen, mem_signed_mode;
  logic [1:0]  mem_width_mode;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  load_store_unit #(
    .BASE_ADDR  (BASE),
    .SLICE_BYTES(SLICE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_ren        (mem_ren),
    .mem_wen        (mem_wen),
    .mem_width_mode (mem_width_mode),
    .mem_signed_mode(mem_signed_mode),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory slice: byte-addressed, little-endian, does its own extraction and extension.
  logic [7:0]  slice_mem [SLICE] = '{default: 8'h00};
  int unsigned sl_nb;
  logic [31:0] sl_v;

  always_comb begin
    sl_nb = (mem_width_mode == 2'b10) ? 1 : ((mem_width_mode == 2'b01) ? 2 : 4);
    sl_v  = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(sl_nb)) sl_v[8*i +: 8] = slice_mem[mem_addr + 11'(i)];
    if (mem_signed_mode && sl_nb == 1)      sl_v = {{24{sl_v[7]}}, sl_v[7:0]};
    else if (mem_signed_mode && sl_nb == 2) sl_v = {{16{sl_v[15]}}, sl_v[15:0]};
    mem_rdata = sl_v;
  end

  always @(posedge clk)
    if (mem_wen)
      for (int i = 0; i < 4; i++)
        if (i < int'(sl_nb)) slice_mem[mem_addr + 11'(i)] <= mem_wdata[8*i +: 8];

  // Reference model: architectural byte contents of the slice.
  logic [7:0] ref_mem [SLICE];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int unsigned f3_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic exp_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic f;
    f = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    if ((addr - BASE) >= SLICE) f = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01 && (addr % 2) != 0) f = 1'b1;
    if (f3[1:0] == 2'b10 && (addr % 4) != 0) f = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [10:0] off);
    longint      v;
    int unsigned nb;
    nb = f3_bytes(f3);
    v  = 0;
    for (int i = 0; i < int'(nb); i++)
      v += longint'(ref_mem[(int'(off) + i) % SLICE]) << (8 * i);
    if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v -= (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [10:0] off, input logic [31:0] wd);
    for (int i = 0; i < int'(f3_bytes(f3)); i++)
      ref_mem[(int'(off) + i) % SLICE] = 8'(wd >> (8 * i));
  endtask

  task automatic outs_zero(input string pfx);
    chk({pfx, "_ctl"}, 32'({req_ready, resp_valid, resp_err, mem_ren, mem_wen,
                            mem_width_mode, mem_signed_mode}), 32'd0);
    chk({pfx, "_rdata"}, resp_rdata, 32'd0);
    chk({pfx, "_maddr"}, 32'(mem_addr), 32'd0);
    chk({pfx, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int unsigned hold);
    logic        e_err, e_signed;
    logic [1:0]  e_width;
    logic [31:0] e_rd;
    logic [10:0] off;
    int unsigned nb, e_lat, e_ren, e_wen, n, ren_c, wen_c;
    nb       = f3_bytes(f3);
    e_err    = exp_fault(we, f3, addr);
    off      = 11'(addr - BASE);
    e_width  = (nb == 4) ? 2'b00 : ((nb == 2) ? 2'b01 : 2'b10);
    e_signed = !f3[2] && nb < 4;
    e_rd     = (e_err || we) ? 32'h0 : ref_load(f3, off);
    e_lat    = e_err ? 1 : (we ? 2 : 3);
    e_ren    = (e_err || we) ? 0 : 2;
    e_wen    = (!e_err && we) ? 1 : 0;

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    n = 1; ren_c = 0; wen_c = 0;
    while (!resp_valid && n < 8) begin
      if (mem_ren || mem_wen) begin
        chk("mem_addr", 32'(mem_addr), 32'(off));
        chk("mem_width", 32'(mem_width_mode), 32'(e_width));
        chk("mem_signed", 32'(mem_signed_mode), 32'(e_signed));
        if (we) chk("mem_wdata", mem_wdata, wd);
      end
      chk("strobe_excl", 32'(mem_ren & mem_wen), 32'd0);
      ren_c += 32'(mem_ren);
      wen_c += 32'(mem_wen);
      @(negedge clk);
      n++;
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", n, e_lat);
    chk("ren_cycles", ren_c, e_ren);
    chk("wen_cycles", wen_c, e_wen);
    chk("resp_err", 32'(resp_err), 32'(e_err));
    chk("resp_rdata", resp_rdata, e_rd);
    chk("mem_idle_resp", 32'({mem_ren, mem_wen, mem_width_mode, mem_signed_mode, mem_addr}) | mem_wdata, 32'd0);

    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, e_rd);
      chk("hold_err", 32'(resp_err), 32'(e_err));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    chk("ready_in_handshake", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    if (we && !e_err) ref_store(f3, off, wd);
  endtask

  // Reset hits a legal word access at cycle at_cycle after acceptance (1 = ISSUE, 2 = CAPTURE).
  task automatic abort_txn(input logic we, input logic [31:0] addr, input int unsigned at_cycle);
    req_valid = 1'b1; req_we = we; req_funct3 = 3'b010; req_addr = addr; req_wdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i < int'(at_cycle); i++) @(negedge clk);
    if (we) chk("abort_pre_wen", 32'(mem_wen), 32'd1);
    else    chk("abort_pre_ren", 32'(mem_ren), 32'd1);
    rst = 1'b1;
    #1;
    outs_zero("abort");
    repeat (2) @(negedge clk);
    outs_zero("abort_hold");
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_noresp", 32'(resp_valid), 32'd0);
    end
  endtask

  logic [31:0] ra;

  initial begin
    for (int i = 0; i < int'(SLICE); i++) ref_mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs_zero("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    @(negedge clk);

    run_txn(1'b1, 3'b010, BASE + 32'h10, 32'hDEADBEEF, 0);
    run_txn(1'b0, 3'b010, BASE + 32'h10, 32'h0, 0);
    run_txn(1'b1, 3'b000, BASE + 32'h13, 32'h0000_0080, 1);
    run_txn(1'b0, 3'b000, BASE + 32'h13, 32'h0, 0);
    run_txn(1'b0, 3'b100, BASE + 32'h13, 32'h0, 0);
    run_txn(1'b0, 3'b010, BASE + 32'h800, 32'h0, 0);
    run_txn(1'b0, 3'b001, BASE + 32'h11, 32'h0, 0);
    run_txn(1'b0, 3'b010, BASE + 32'h10, 32'h0, 5);
    run_txn(1'b1, 3'b100, BASE + 32'h20, 32'h1234_5678, 0);
    run_txn(1'b0, 3'b111, BASE + 32'h20, 32'h0, 0);

    abort_txn(1'b0, BASE + 32'h10, 2);
    abort_txn(1'b1, BASE + 32'h20, 1);
    run_txn(1'b0, 3'b010, BASE + 32'h20, 32'h0, 0);
    run_txn(1'b0, 3'b010, BASE + 32'h10, 32'h0, 0);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1, 2, 3: ra = BASE + $urandom_range(0, 63);
        default: ra = BASE + $urandom_range(0, SLICE - 1);
      endcase
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
              $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
